elevator_dispatch: RTL and testbench
====================================

Name: elevator_dispatch

Overview:
Call scheduler sitting in front of the car-position FSM. Latches hall/car calls for the six car positions (1, 2, 2M, 3, 3M, 4) and selects one target at a time using SCAN ordering. Drives the one-hot destination into the car FSM and sequences a door-dwell period at each served stop. Also drives pending-call lamps.

Parameters:
N_POS, 6, number of car positions; index 0 = floor 1 (bottom), 5 = floor 4 (top)
DWELL_CYCLES, 8, clock cycles door_open stays high per stop (>=1)
DW, 4, dwell counter width; must satisfy 2**DW > DWELL_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset asserted)
call_btn  in  N_POS  call requests, already synchronised; any-cycle-high sets request
cur_pos  in  N_POS  one-hot current car position from car FSM
arrived  in  1  car stationary at cur_pos this cycle
dest  out  N_POS  one-hot target to car FSM; all-zero = hold
dir_up  out  1  current sweep direction (1 = up)
door_open  out  1  door dwell active
pending  out  N_POS  latched outstanding calls (lamps)
busy  out  1  state != IDLE or pending != 0
pos_err  out  1  cur_pos not one-hot this cycle

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, pending=0, dest=0, dir_up=1, door_open=0, dwell count=0. Applies mid-move/mid-dwell; no request survives.
- pending[i] set the cycle after call_btn[i]=1. Cleared in any cycle where state==DOOR and cur_pos[i]=1. Simultaneous set and clear on same bit: clear wins. Calls at other positions during DOOR are latched normally.
- above/below masks: pending bits strictly above/below the cur_pos index.
- States: IDLE, MOVE, DOOR (encoded in package enum).
- IDLE:
  - dest=0.
  - If pos_err: stay.
  - Elif arrived and pending & cur_pos: go to DOOR.
  - Elif pending!=0, pick direction:
    - keep dir_up if calls remain that way;
    - else reverse if calls exist the other way;
    - dest = nearest pending in the chosen direction.
  - Register dest and dir_up; go to MOVE.
- MOVE:
  - dest held.
  - Re-target: if a new pending bit lies strictly between cur_pos and dest in the travel direction, dest moves to the nearest such bit next cycle. Never re-targets behind the car.
  - When arrived and cur_pos==dest: dest=0 and go to DOOR.
  - If the targeted call disappears (only possible via reset), go to IDLE.
- DOOR:
  - door_open=1 for exactly DWELL_CYCLES consecutive cycles; counter loads 0 on entry and increments.
  - At count==DWELL_CYCLES-1: go to IDLE, door_open=0 next cycle.
  - dest=0 throughout.
- Latency:
  - call_btn -> pending: 1 cycle.
  - pending -> dest from IDLE: 1 cycle (dest valid 2 cycles after button).
  - arrival -> door_open: 1 cycle.
- pos_err: combinational. In MOVE/DOOR an invalid cur_pos freezes state, dest and counter until valid.
- busy is combinational from registered state and pending.
- No wrap-around: the top position has no "above" and the bottom has no "below"; direction flips at the extremes.

Decomposition:
- Package elevator_pkg: N_POS default, state enum {IDLE, MOVE, DOOR}, position index constants POS_1, POS_2, POS_2M, POS_3, POS_3M, POS_4.
- Sub-module nearest_call: combinational. Inputs pending, cur_pos, dir_up. Outputs one-hot nearest-above, nearest-below, has_above, has_below.
- Top contains the pending register, FSM and dwell counter.

Test Plan:
1. Reset held low 2 cycles during DOOR, then released -> pending=0, dest=0, door_open=0, dir_up=1, busy=0.
2. cur_pos=POS_1 (000001), arrived=1, pulse call_btn=100000 -> pending=100000 at t+1, dest=100000 and dir_up=1 at t+2. Later cur_pos=100000 with arrived -> door_open high for 8 cycles, pending=0, then IDLE with busy=0.
3. Moving up from POS_1 to POS_4, pulse call_btn=000100 while cur_pos=000010 -> dest becomes 000100 next cycle. Same call arriving when cur_pos=001000 -> dest stays 100000.
4. Car idle at POS_3 (001000), pending=100001, dir_up=0 -> dest=000001, dir_up=0. Serve it, then dest=100000 with dir_up=1.
5. During DOOR at 001000, hold call_btn=001000 every cycle -> pending[3] stays 0. Call_btn=000010 in same window -> pending=000010 after exit.
6. cur_pos=000110 for 3 cycles during MOVE -> pos_err=1, dest unchanged, state held. Restore valid value -> normal resume.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call dispatcher.
package elevator_pkg;

  localparam int unsigned N_POS_DEFAULT = 6;

  // Position indices, bottom to top
  localparam int unsigned POS_1  = 0;
  localparam int unsigned POS_2  = 1;
  localparam int unsigned POS_2M = 2;
  localparam int unsigned POS_3  = 3;
  localparam int unsigned POS_3M = 4;
  localparam int unsigned POS_4  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

endpackage

// File: rtl/elevator_dispatch_nearest_call.sv
// Finds the closest pending call strictly above and strictly below the car.
module nearest_call #(
  parameter int unsigned N_POS = 6
) (
  input  logic [N_POS-1:0] pending,
  input  logic [N_POS-1:0] cur_pos,
  input  logic             dir_up,
  output logic [N_POS-1:0] near_above,
  output logic [N_POS-1:0] near_below,
  output logic [N_POS-1:0] near_fwd,
  output logic             has_above,
  output logic             has_below
);

  // Ascending scan: first pending bit after the car position
  always_comb begin
    logic seen;
    logic found;
    seen       = 1'b0;
    found      = 1'b0;
    near_above = '0;
    for (int i = 0; i < int'(N_POS); i++) begin
      if (seen && pending[i] && !found) begin
        near_above[i] = 1'b1;
        found         = 1'b1;
      end
      if (cur_pos[i]) seen = 1'b1;
    end
  end

  // Descending scan: first pending bit below the car position
  always_comb begin
    logic seen;
    logic found;
    seen       = 1'b0;
    found      = 1'b0;
    near_below = '0;
    for (int i = int'(N_POS) - 1; i >= 0; i--) begin
      if (seen && pending[i] && !found) begin
        near_below[i] = 1'b1;
        found         = 1'b1;
      end
      if (cur_pos[i]) seen = 1'b1;
    end
  end

  assign has_above = |near_above;
  assign has_below = |near_below;
  assign near_fwd  = dir_up ? near_above : near_below;

endmodule

// File: rtl/elevator_dispatch.sv
// SCAN call scheduler: latches calls, picks one destination at a time and
// sequences the door dwell at each served stop.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int unsigned N_POS        = N_POS_DEFAULT,
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned DW           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_POS-1:0] call_btn,
  input  logic [N_POS-1:0] cur_pos,
  input  logic             arrived,
  output logic [N_POS-1:0] dest,
  output logic             dir_up,
  output logic             door_open,
  output logic [N_POS-1:0] pending,
  output logic             busy,
  output logic             pos_err
);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_t           state, state_n;
  logic [N_POS-1:0] pending_n, dest_n, clr;
  logic [N_POS-1:0] near_above, near_below, near_fwd;
  logic             has_above, has_below;
  logic             dir_up_n, door_open_n;
  logic [DW-1:0]    dwell_cnt, dwell_cnt_n;

  nearest_call #(.N_POS(N_POS)) u_nearest (
    .pending    (pending),
    .cur_pos    (cur_pos),
    .dir_up     (dir_up),
    .near_above (near_above),
    .near_below (near_below),
    .near_fwd   (near_fwd),
    .has_above  (has_above),
    .has_below  (has_below)
  );

  // Serving a stop clears its lamp; clear beats a simultaneous new press
  assign clr       = (state == DOOR) ? cur_pos : '0;
  assign pending_n = (pending | call_btn) & ~clr;
  assign pos_err   = !$onehot(cur_pos);
  assign busy      = (state != IDLE) || (pending != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      dest      <= '0;
      dir_up    <= 1'b1;
      door_open <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      dest      <= dest_n;
      dir_up    <= dir_up_n;
      door_open <= door_open_n;
      dwell_cnt <= dwell_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    dest_n      = dest;
    dir_up_n    = dir_up;
    dwell_cnt_n = dwell_cnt;
    unique case (state)
      IDLE: begin
        dest_n = '0;
        if (!pos_err) begin
          if (arrived && ((pending & cur_pos) != '0)) begin
            state_n     = DOOR;
            dwell_cnt_n = '0;
          end else if (dir_up ? has_above : has_below) begin
            state_n = MOVE;
            dest_n  = dir_up ? near_above : near_below;
          end else if (dir_up ? has_below : has_above) begin
            state_n  = MOVE;
            dir_up_n = !dir_up;
            dest_n   = dir_up ? near_below : near_above;
          end
        end
      end
      MOVE: begin
        if (!pos_err) begin
          if ((dest & pending) == '0) begin
            state_n = IDLE;
            dest_n  = '0;
          end else if (arrived && (cur_pos == dest)) begin
            state_n     = DOOR;
            dest_n      = '0;
            dwell_cnt_n = '0;
          end else if ((near_fwd != '0) &&
                       (dir_up ? (near_fwd < dest) : (near_fwd > dest))) begin
            // A new call between the car and its target is served first
            dest_n = near_fwd;
          end
        end
      end
      DOOR: begin
        dest_n = '0;
        if (!pos_err) begin
          if (dwell_cnt == DWELL_LAST) state_n = IDLE;
          else                         dwell_cnt_n = dwell_cnt + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        dest_n  = '0;
      end
    endcase
    door_open_n = (state_n == DOOR);
  end

endmodule

// File: tb/tb_elevator_dispatch.sv
// Scoreboard bench for elevator_dispatch: expectations queued with stimulus,
// drained one cycle later.
module tb_elevator_dispatch;

  localparam int unsigned N = 6;

  typedef enum int {S_DEST, S_PEND, S_DIR, S_DOOR, S_BUSY, S_PERR} sig_t;
  typedef struct {
    string        tag;
    sig_t         sig;
    logic [N-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] call_btn;
  logic [N-1:0] cur_pos;
  logic         arrived;
  logic [N-1:0] dest;
  logic         dir_up;
  logic         door_open;
  logic [N-1:0] pending;
  logic         busy;
  logic         pos_err;

  always #5 clk = ~clk;

  elevator_dispatch #(.N_POS(N), .DWELL_CYCLES(8), .DW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .call_btn  (call_btn),
    .cur_pos   (cur_pos),
    .arrived   (arrived),
    .dest      (dest),
    .dir_up    (dir_up),
    .door_open (door_open),
    .pending   (pending),
    .busy      (busy),
    .pos_err   (pos_err)
  );

  task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] observe(input sig_t s);
    case (s)
      S_DEST:  return dest;
      S_PEND:  return pending;
      S_DIR:   return N'(dir_up);
      S_DOOR:  return N'(door_open);
      S_BUSY:  return N'(busy);
      S_PERR:  return N'(pos_err);
      default: return 'x;
    endcase
  endfunction

  task automatic expect_out(input string tag, input sig_t s, input logic [N-1:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then compare everything queued for this cycle
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  // Remaining 7 dwell cycles after the entry cycle, then the exit cycle
  task automatic door_dwell(input string tag, input logic [N-1:0] pend_after);
    for (int k = 1; k < 8; k++) begin
      expect_out({tag, "_door"}, S_DOOR, 6'd1);
      expect_out({tag, "_dest"}, S_DEST, 6'd0);
      tick();
    end
    expect_out({tag, "_exit_door"}, S_DOOR, 6'd0);
    expect_out({tag, "_exit_pend"}, S_PEND, pend_after);
    tick();
  endtask

  initial begin
    reset    = 1'b0;
    call_btn = '0;
    cur_pos  = 6'b000001;
    arrived  = 1'b1;
    tick();
    expect_out("rst_pend", S_PEND, 6'd0);
    expect_out("rst_dest", S_DEST, 6'd0);
    expect_out("rst_door", S_DOOR, 6'd0);
    expect_out("rst_dir",  S_DIR,  6'd1);
    expect_out("rst_busy", S_BUSY, 6'd0);
    expect_out("rst_perr", S_PERR, 6'd0);
    tick();
    reset = 1'b1;

    // Top-floor call from the bottom
    call_btn = 6'b100000;
    expect_out("latch_pend", S_PEND, 6'b100000);
    expect_out("latch_dest", S_DEST, 6'd0);
    expect_out("latch_busy", S_BUSY, 6'd1);
    tick();
    call_btn = '0;
    expect_out("launch_dest", S_DEST, 6'b100000);
    expect_out("launch_dir",  S_DIR,  6'd1);
    tick();

    // New call ahead of the car re-targets
    cur_pos = 6'b000010; arrived = 1'b0; call_btn = 6'b000100;
    expect_out("ahead_pend", S_PEND, 6'b100100);
    expect_out("ahead_dest_hold", S_DEST, 6'b100000);
    tick();
    call_btn = '0;
    expect_out("retarget_dest", S_DEST, 6'b000100);
    expect_out("retarget_dir",  S_DIR,  6'd1);
    tick();

    // Arrive at 2M; hold its button through the dwell, plus a call at 2
    cur_pos = 6'b000100; arrived = 1'b1;
    expect_out("arr2m_door", S_DOOR, 6'd1);
    expect_out("arr2m_dest", S_DEST, 6'd0);
    tick();
    for (int k = 1; k < 8; k++) begin
      call_btn = (k == 2) ? 6'b000110 : 6'b000100;
      expect_out("dwell2m_door", S_DOOR, 6'd1);
      expect_out("dwell2m_dest", S_DEST, 6'd0);
      if (k == 7) expect_out("dwell2m_pend", S_PEND, 6'b100010);
      tick();
    end
    call_btn = 6'b000100;
    expect_out("exit2m_door", S_DOOR, 6'd0);
    expect_out("exit2m_pend", S_PEND, 6'b100010);
    tick();
    call_btn = '0;
    expect_out("resume_dest", S_DEST, 6'b100000);
    expect_out("resume_dir",  S_DIR,  6'd1);
    tick();

    // Call behind the car must not re-target
    cur_pos = 6'b001000; arrived = 1'b0; call_btn = 6'b000100;
    expect_out("behind_pend", S_PEND, 6'b100110);
    expect_out("behind_dest", S_DEST, 6'b100000);
    tick();
    call_btn = '0;
    expect_out("behind_dest2", S_DEST, 6'b100000);
    tick();
    cur_pos = 6'b010000;
    expect_out("behind_dest3", S_DEST, 6'b100000);
    tick();
    cur_pos = 6'b100000; arrived = 1'b1;
    expect_out("arr4_door", S_DOOR, 6'd1);
    expect_out("arr4_dest", S_DEST, 6'd0);
    tick();
    door_dwell("dwell4", 6'b000110);

    // Nothing above the top: sweep reverses
    expect_out("flip_dest", S_DEST, 6'b000100);
    expect_out("flip_dir",  S_DIR,  6'd0);
    tick();
    cur_pos = 6'b010000; arrived = 1'b0;
    expect_out("down_dest", S_DEST, 6'b000100);
    tick();

    // Invalid position freezes the move
    cur_pos = 6'b000110;
    for (int k = 0; k < 3; k++) begin
      expect_out("perr_flag", S_PERR, 6'd1);
      expect_out("perr_dest", S_DEST, 6'b000100);
      expect_out("perr_door", S_DOOR, 6'd0);
      expect_out("perr_busy", S_BUSY, 6'd1);
      tick();
    end
    cur_pos = 6'b001000;
    expect_out("perr_clear", S_PERR, 6'd0);
    expect_out("perr_resume_dest", S_DEST, 6'b000100);
    tick();
    cur_pos = 6'b000100; arrived = 1'b1; call_btn = 6'b100000;
    expect_out("arr2m_b_door", S_DOOR, 6'd1);
    expect_out("arr2m_b_pend", S_PEND, 6'b100110);
    tick();
    call_btn = '0;
    door_dwell("dwell2m_b", 6'b100010);

    // Heading down: keep going down despite the call above
    expect_out("keep_dir_dest", S_DEST, 6'b000010);
    expect_out("keep_dir_dir",  S_DIR,  6'd0);
    tick();
    cur_pos = 6'b000010;
    expect_out("arr2_door", S_DOOR, 6'd1);
    expect_out("arr2_dest", S_DEST, 6'd0);
    tick();
    door_dwell("dwell2", 6'b100000);
    expect_out("rev_up_dest", S_DEST, 6'b100000);
    expect_out("rev_up_dir",  S_DIR,  6'd1);
    tick();
    cur_pos = 6'b001000; arrived = 1'b0;
    expect_out("up2_dest", S_DEST, 6'b100000);
    tick();
    cur_pos = 6'b100000; arrived = 1'b1;
    expect_out("arr4_b_door", S_DOOR, 6'd1);
    tick();
    call_btn = 6'b000001;
    expect_out("dwell4_b_door", S_DOOR, 6'd1);
    expect_out("dwell4_b_pend", S_PEND, 6'b000001);
    tick();

    // Reset in the middle of a dwell drops everything
    call_btn = '0;
    reset    = 1'b0;
    tick();
    expect_out("mrst_pend", S_PEND, 6'd0);
    expect_out("mrst_dest", S_DEST, 6'd0);
    expect_out("mrst_door", S_DOOR, 6'd0);
    expect_out("mrst_dir",  S_DIR,  6'd1);
    expect_out("mrst_busy", S_BUSY, 6'd0);
    tick();
    reset = 1'b1;
    expect_out("post_rst_door", S_DOOR, 6'd0);
    expect_out("post_rst_busy", S_BUSY, 6'd0);
    expect_out("post_rst_dest", S_DEST, 6'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
